coproc_seq_ctrl: RTL and testbench



---
 rtl/coproc_pkg.sv | 28 ++
 rtl/coproc_seq_ctrl_beat_cnt.sv | 32 +++
 rtl/coproc_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_coproc_seq_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared types and constants for the filter coprocessor sequencer.
// Holds the FSM state encoding, image geometry and filter opcodes.
package coproc_pkg;

  localparam int IMG_DIM   = 256;
  localparam int PIX_TOTAL = IMG_DIM * IMG_DIM;
  localparam int CNT_W     = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FILL  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OP_BYPASS  = 3'd0,
    OP_BLUR    = 3'd1,
    OP_SHARPEN = 3'd2,
    OP_SOBEL   = 3'd3,
    OP_MEDIAN  = 3'd4,
    OP_ERODE   = 3'd5,
    OP_DILATE  = 3'd6,
    OP_THRESH  = 3'd7
  } op_e;

endpackage

// File: rtl/coproc_seq_ctrl_beat_cnt.sv
// Saturating beat counter with synchronous clear and a terminal flag.
module beat_cnt #(
  parameter int             W       = coproc_pkg::CNT_W,
  parameter logic [W-1:0]   MAX_VAL = W'(coproc_pkg::PIX_TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_term
);

  logic [W-1:0] r_cnt;

  // Count register: clear has priority, increments stop at MAX_VAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_VAL)) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == MAX_VAL);

endmodule

// File: rtl/coproc_seq_ctrl.sv
// Pass sequencer for the filter coprocessor: accepts a CPU command, streams
// PIX_TOTAL input beats into the address calculator and waits for all results.
module coproc_seq_ctrl #(
  parameter int IMG_DIM   = coproc_pkg::IMG_DIM,
  parameter int PIX_TOTAL = IMG_DIM * IMG_DIM
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cmd_valid,
  input  logic [2:0] i_cmd_op,
  output logic       o_cmd_ready,
  input  logic       i_abort,
  input  logic       i_irq_clr,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_irq,
  output logic [2:0] o_op_q,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic       o_ac_start,
  output logic       o_ac_we_in,
  output logic       o_ac_re,
  input  logic       i_ac_we_out,
  input  logic       i_out_ready
);
  import coproc_pkg::*;

  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_TOTAL - 1);

  state_e           r_state;
  state_e           w_next;
  op_e              r_op_q;
  logic             r_irq;
  logic             w_active;
  logic             w_start;
  logic             w_abort;
  logic             w_clr;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_in_last;
  logic             w_out_last;
  logic             w_in_term;
  logic             w_out_term;
  logic [CNT_W-1:0] w_in_cnt;
  logic [CNT_W-1:0] w_out_cnt;

  assign w_active   = (r_state == ST_FILL) || (r_state == ST_DRAIN);
  assign w_start    = (r_state == ST_IDLE) && i_cmd_valid;
  assign w_abort    = i_abort && (w_active || (r_state == ST_START));
  assign w_clr      = w_start || w_abort;
  assign w_in_fire  = (r_state == ST_FILL) && i_in_valid;
  assign w_out_fire = w_active && i_ac_we_out;
  // Completion looks at the beat arriving this cycle, not just the stored count
  assign w_in_last  = w_in_term || (w_in_fire && (w_in_cnt == PIX_LAST));
  assign w_out_last = w_out_term || (w_out_fire && (w_out_cnt == PIX_LAST));

  beat_cnt #(.W(CNT_W), .MAX_VAL(CNT_W'(PIX_TOTAL))) u_in_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_inc  (w_in_fire),
    .o_cnt  (w_in_cnt),
    .o_term (w_in_term)
  );

  beat_cnt #(.W(CNT_W), .MAX_VAL(CNT_W'(PIX_TOTAL))) u_out_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_inc  (w_out_fire),
    .o_cnt  (w_out_cnt),
    .o_term (w_out_term)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort outranks completion
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) w_next = ST_START;
        else             w_next = ST_IDLE;
      end
      ST_START: begin
        if (i_abort) w_next = ST_IDLE;
        else         w_next = ST_FILL;
      end
      ST_FILL: begin
        if (i_abort)        w_next = ST_IDLE;
        else if (w_in_last) w_next = ST_DRAIN;
        else                w_next = ST_FILL;
      end
      ST_DRAIN: begin
        if (i_abort)         w_next = ST_IDLE;
        else if (w_out_last) w_next = ST_DONE;
        else                 w_next = ST_DRAIN;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Opcode latch and sticky irq; setting in DONE beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_q <= OP_BYPASS;
      r_irq  <= 1'b0;
    end else begin
      if (w_start) r_op_q <= op_e'(i_cmd_op);
      else         r_op_q <= r_op_q;
      if (r_state == ST_DONE) r_irq <= 1'b1;
      else if (i_irq_clr)     r_irq <= 1'b0;
      else                    r_irq <= r_irq;
    end
  end

  // State-decoded outputs
  always_comb begin
    o_cmd_ready = (r_state == ST_IDLE);
    o_busy      = (r_state != ST_IDLE);
    o_ac_start  = (r_state == ST_START);
    o_in_ready  = (r_state == ST_FILL);
    o_done      = (r_state == ST_DONE);
    o_ac_we_in  = i_in_valid && (r_state == ST_FILL);
    o_ac_re     = i_out_ready && w_active;
    o_op_q      = r_op_q;
    o_irq       = r_irq;
  end

endmodule

// File: tb/tb_coproc_seq_ctrl.sv
// Directed bench for coproc_seq_ctrl with a scaled-down 16x16 image (256 beats)
// and a small echo model standing in for the address calculator.
module tb_coproc_seq_ctrl;

  localparam int PIX = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, abort, irq_clr, in_valid, out_ready;
  logic [2:0] cmd_op;
  logic       cmd_ready, busy, done, irq, in_ready, ac_start, ac_we_in, ac_re;
  logic [2:0] op_q;
  wire        ac_we_out;

  int n_cmp = 0;
  int n_err = 0;
  int n_we_in = 0;
  int n_we_out = 0;
  int n_done = 0;
  int pend = 0;
  logic echo_r = 1'b0;

  int r_cyc, r_in, r_out, r_stall, r_re_bad;
  bit r_timeout;

  always #5 clk = ~clk;

  coproc_seq_ctrl #(.IMG_DIM(16), .PIX_TOTAL(PIX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cmd_valid (cmd_valid),
    .i_cmd_op    (cmd_op),
    .o_cmd_ready (cmd_ready),
    .i_abort     (abort),
    .i_irq_clr   (irq_clr),
    .o_busy      (busy),
    .o_done      (done),
    .o_irq       (irq),
    .o_op_q      (op_q),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_ac_start  (ac_start),
    .o_ac_we_in  (ac_we_in),
    .o_ac_re     (ac_re),
    .i_ac_we_out (ac_we_out),
    .i_out_ready (out_ready)
  );

  // Address-calculator model: each written beat comes back one cycle later, held while out_ready=0
  assign ac_we_out = echo_r & out_ready;

  always @(negedge clk) begin
    if (ac_we_in === 1'b1) n_we_in++;
    if ((ac_we_out === 1'b1) && (busy === 1'b1)) n_we_out++;
    if (done === 1'b1) n_done++;
    if (busy !== 1'b1) pend = 0;
    else begin
      if (ac_we_out === 1'b1) pend--;
      if (ac_we_in === 1'b1) pend++;
    end
  end

  always @(posedge clk) echo_r <= (pend > 0);

  task automatic run_pass(input logic [2:0] op, input bit toggle, input bit stall);
    int b_in, b_out;
    b_in = n_we_in;
    b_out = n_we_out;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; in_valid = !toggle; out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    r_cyc = 0; r_stall = 0; r_re_bad = 0; r_timeout = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      r_cyc++;
      if (done === 1'b1) begin
        r_timeout = 1'b0;
        break;
      end
      if (toggle) in_valid = ((r_cyc % 2) == 1);
      if (stall && busy && !in_ready && !ac_start && (r_stall < 100)) begin
        out_ready = 1'b0;
        r_stall++;
        #1;
        if (ac_re !== 1'b0) r_re_bad++;
      end else begin
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    r_in = n_we_in - b_in;
    r_out = n_we_out - b_out;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; abort = 1'b0; irq_clr = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #3;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if ({done, irq, ac_start, in_ready} !== 4'b0000) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {done, irq, ac_start, in_ready}); end
    n_cmp++; if ({ac_we_in, ac_re} !== 2'b00) begin n_err++; $display("FAIL rst_ac: got %b want 00", {ac_we_in, ac_re}); end
    n_cmp++; if (op_q !== 3'd0) begin n_err++; $display("FAIL rst_op_q: got %0d want 0", op_q); end
    #19 rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_start;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd3;
    @(posedge clk); #1;
    n_cmp++; if (ac_start !== 1'b1) begin n_err++; $display("FAIL start_pulse: got %b want 1", ac_start); end
    n_cmp++; if (op_q !== 3'd3) begin n_err++; $display("FAIL start_op_q: got %0d want 3", op_q); end
    n_cmp++; if ({busy, cmd_ready} !== 2'b10) begin n_err++; $display("FAIL start_busy_ready: got %b want 10", {busy, cmd_ready}); end
    cmd_op = 3'd5;
    @(posedge clk); #1;
    n_cmp++; if ({ac_start, in_ready} !== 2'b01) begin n_err++; $display("FAIL start_one_cycle: got %b want 01", {ac_start, in_ready}); end
    n_cmp++; if (op_q !== 3'd3) begin n_err++; $display("FAIL busy_cmd_ignored: got %0d want 3", op_q); end
    cmd_valid = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++; if ({cmd_ready, busy, done} !== 3'b100) begin n_err++; $display("FAIL start_abort_idle: got %b want 100", {cmd_ready, busy, done}); end
  endtask

  task automatic test_full_pass;
    int b_done;
    b_done = n_done;
    run_pass(3'd1, 1'b0, 1'b0);
    n_cmp++; if (r_timeout !== 1'b0) begin n_err++; $display("FAIL full_timeout: got %b want 0", r_timeout); end
    n_cmp++; if (r_cyc !== 258) begin n_err++; $display("FAIL full_latency: got %0d want 258", r_cyc); end
    n_cmp++; if (r_in !== PIX) begin n_err++; $display("FAIL full_we_in: got %0d want %0d", r_in, PIX); end
    n_cmp++; if (r_out !== PIX) begin n_err++; $display("FAIL full_we_out: got %0d want %0d", r_out, PIX); end
    @(posedge clk); #1;
    n_cmp++; if ({done, busy, irq} !== 3'b001) begin n_err++; $display("FAIL full_after: got %b want 001", {done, busy, irq}); end
    n_cmp++; if (n_done - b_done !== 1) begin n_err++; $display("FAIL full_done_count: got %0d want 1", n_done - b_done); end
  endtask

  task automatic test_stall;
    int b_done;
    b_done = n_done;
    run_pass(3'd4, 1'b1, 1'b1);
    n_cmp++; if (r_timeout !== 1'b0) begin n_err++; $display("FAIL stall_timeout: got %b want 0", r_timeout); end
    n_cmp++; if (r_in !== PIX) begin n_err++; $display("FAIL stall_we_in: got %0d want %0d", r_in, PIX); end
    n_cmp++; if (r_out !== PIX) begin n_err++; $display("FAIL stall_we_out: got %0d want %0d", r_out, PIX); end
    n_cmp++; if (r_stall !== 100) begin n_err++; $display("FAIL stall_length: got %0d want 100", r_stall); end
    n_cmp++; if (r_re_bad !== 0) begin n_err++; $display("FAIL stall_ac_re: got %0d want 0", r_re_bad); end
    @(posedge clk); #1;
    n_cmp++; if (n_done - b_done !== 1) begin n_err++; $display("FAIL stall_done_count: got %0d want 1", n_done - b_done); end
  endtask

  task automatic test_abort;
    int b_done, b_in;
    bit hit;
    b_done = n_done; b_in = n_we_in; hit = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (n_we_in - b_in == 100) begin hit = 1'b1; break; end
    end
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL abort_reach_100: got %b want 1", hit); end
    abort = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++; if ({cmd_ready, busy, in_ready} !== 3'b100) begin n_err++; $display("FAIL abort_idle: got %b want 100", {cmd_ready, busy, in_ready}); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL abort_irq_kept: got %b want 1", irq); end
    @(posedge clk); #1;
    n_cmp++; if (n_done - b_done !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", n_done - b_done); end
    run_pass(3'd5, 1'b0, 1'b0);
    n_cmp++; if (r_cyc !== 258) begin n_err++; $display("FAIL abort_repass_latency: got %0d want 258", r_cyc); end
    n_cmp++; if (r_in !== PIX) begin n_err++; $display("FAIL abort_repass_we_in: got %0d want %0d", r_in, PIX); end
  endtask

  task automatic test_irq_clr;
    @(posedge clk); #1;
    irq_clr = 1'b1;
    @(posedge clk); #1;
    irq_clr = 1'b0;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear_idle: got %b want 0", irq); end
    run_pass(3'd7, 1'b0, 1'b0);
    irq_clr = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set_wins: got %b want 1", irq); end
    @(posedge clk); #1;
    irq_clr = 1'b0;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear_later: got %b want 0", irq); end
  endtask

  task automatic test_reset_mid;
    bit seen_fill, hit;
    seen_fill = 1'b0; hit = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd6; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      if (in_ready === 1'b1) seen_fill = 1'b1;
      if (seen_fill && busy && !in_ready && !done) begin hit = 1'b1; break; end
    end
    n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL rmid_reach_drain: got %b want 1", hit); end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({cmd_ready, busy, done, ac_re} !== 4'b1000) begin n_err++; $display("FAIL rmid_async: got %b want 1000", {cmd_ready, busy, done, ac_re}); end
    n_cmp++; if (op_q !== 3'd0) begin n_err++; $display("FAIL rmid_op_q: got %0d want 0", op_q); end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    run_pass(3'd2, 1'b0, 1'b0);
    n_cmp++; if (r_cyc !== 258) begin n_err++; $display("FAIL rmid_repass_latency: got %0d want 258", r_cyc); end
    n_cmp++; if (r_out !== PIX) begin n_err++; $display("FAIL rmid_repass_we_out: got %0d want %0d", r_out, PIX); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_full_pass();
    test_stall();
    test_abort();
    test_irq_clr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
